// File: rtl/spart_core.sv
// spart_core: bus-side SPART peripheral.
// Holds a programmable baud generator (16x oversample tick), an 8N1
// transmitter with a one-byte buffer and an 8N1 receiver with a one-byte
// buffer, all reached through the iocs/iorw/ioaddr/databus register port.
//
// Bus handshake: there is no wait state. A register access takes effect on
// the rising clk edge of any cycle with iocs=1. Read data is driven
// combinationally for the whole cycle in which iocs & iorw select address
// 00 or 01. Software polls tbr before writing 00 and polls rda before
// reading 00.
module spart_core #(
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd162,
   parameter int          OVERSAMPLE      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   // Last tick of a bit time, and the tick that lands mid-way through the start bit.
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Register port decode
   logic wr_tx, rd_rx, wr_div_lo, wr_div_hi, div_wr, bus_oe;
   logic [7:0] rx_buf;

   assign wr_tx     = iocs & ~iorw & (ioaddr == 2'b00);
   assign rd_rx     = iocs &  iorw & (ioaddr == 2'b00);
   assign wr_div_lo = iocs & ~iorw & (ioaddr == 2'b10);
   assign wr_div_hi = iocs & ~iorw & (ioaddr == 2'b11);
   assign div_wr    = wr_div_lo | wr_div_hi;
   assign bus_oe    = iocs & iorw & ~ioaddr[1];

   assign databus = bus_oe ? (ioaddr[0] ? {6'b0, tbr, rda} : rx_buf) : 8'hzz;

   // Baud generator
   logic [15:0] divisor, div_next, div_src, reload_val, baud_cnt;
   logic        tick;

   // Next divisor value being written, and the reload value of the down counter.
   // Divisors 0 and 1 both reload 0, giving a tick every cycle.
   always_comb begin
      div_next   = wr_div_lo ? {divisor[15:8], databus} : {databus, divisor[7:0]};
      div_src    = div_wr ? div_next : divisor;
      reload_val = (div_src > 16'd1) ? (div_src - 16'd1) : 16'd0;
   end

   // A divisor write suppresses the tick of that cycle.
   assign tick = (baud_cnt == 16'd0) & ~div_wr;

   // Divisor register and baud down counter; a divisor write restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divisor  <= DEFAULT_DIVISOR;
         baud_cnt <= 16'd0;
      end else begin
         if (div_wr)
            divisor <= div_next;
         if (div_wr || baud_cnt == 16'd0)
            baud_cnt <= reload_val;
         else
            baud_cnt <= baud_cnt - 16'd1;
      end
   end

   // Transmitter
   tx_state_t  tx_state;
   logic [9:0] tx_shift;
   logic [3:0] tx_tick;
   logic [3:0] tx_bit;

   // TX FSM: load a {stop, data, start} frame and shift it out LSB first.
   // txd and tbr are registered so the start bit appears one cycle after the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_shift <= 10'h3ff;
         tx_tick  <= 4'd0;
         tx_bit   <= 4'd0;
         txd      <= 1'b1;
         tbr      <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               txd <= 1'b1;
               tbr <= 1'b1;
               if (wr_tx) begin
                  tx_shift <= {1'b1, databus, 1'b0};
                  tx_tick  <= 4'd0;
                  tx_bit   <= 4'd0;
                  txd      <= 1'b0;
                  tbr      <= 1'b0;
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               // Writes to the TX buffer are ignored while a frame is in flight.
               if (tick) begin
                  if (tx_tick == TICK_LAST) begin
                     tx_tick  <= 4'd0;
                     tx_shift <= {1'b1, tx_shift[9:1]};
                     if (tx_bit == 4'd9) begin
                        tx_bit   <= 4'd0;
                        txd      <= 1'b1;
                        tbr      <= 1'b1;
                        tx_state <= TX_IDLE;
                     end else begin
                        tx_bit <= tx_bit + 4'd1;
                        txd    <= tx_shift[1];
                     end
                  end else begin
                     tx_tick <= tx_tick + 4'd1;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Receiver
   logic rx_meta, rx_sync;

   // Two-flop synchronizer for the asynchronous serial input; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
      end
   end

   rx_state_t  rx_state;
   logic [3:0] rx_tick;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   logic       rx_armed;

   // RX FSM: confirm the start bit at mid-bit, sample 8 data bits every 16 ticks,
   // then check the stop bit. A read of 00 clears rda, but a completing byte in the
   // same cycle wins so rda stays set. After a framing error the line must go
   // high before another start bit is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_tick  <= 4'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
         rx_buf   <= 8'h00;
         rda      <= 1'b0;
         rx_armed <= 1'b1;
      end else begin
         if (rd_rx)
            rda <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_armed) begin
                  if (rx_sync)
                     rx_armed <= 1'b1;
               end else if (!rx_sync) begin
                  rx_tick  <= 4'd0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_tick == TICK_MID) begin
                     rx_tick  <= 4'd0;
                     rx_bit   <= 3'd0;
                     rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rx_tick == TICK_LAST) begin
                     rx_tick  <= 4'd0;
                     rx_shift <= {rx_sync, rx_shift[7:1]};
                     rx_bit   <= rx_bit + 3'd1;
                     if (rx_bit == 3'd7)
                        rx_state <= RX_STOP;
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (rx_tick == TICK_LAST) begin
                     rx_tick  <= 4'd0;
                     rx_state <= RX_IDLE;
                     if (rx_sync) begin
                        rx_buf <= rx_shift;
                        rda    <= 1'b1;
                     end else begin
                        rx_armed <= 1'b0;
                     end
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_core.sv
// tb_spart_core: self-checking bench for spart_core.
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge (or 1 ns after it for the combinational read bus).
module tb_spart_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda;
   logic       tbr;
   logic       txd;
   logic       rxd;

   logic       tb_oe;
   logic [7:0] tb_dout;

   int n_total = 0;
   int n_bad   = 0;

   // Expected serial bits of the transmitted frame and expected RX read data.
   logic [0:0] tx_q[$];
   logic [7:0] rx_q[$];

   assign databus = tb_oe ? tb_dout : 8'hzz;

   spart_core dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus),
      .rda     (rda),
      .tbr     (tbr),
      .txd     (txd),
      .rxd     (rxd)
   );

   // Clock and reset-independent watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      n_bad++;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Single comparison point.
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Driver tasks; each is entered at a falling edge and returns at a falling edge.
   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
      iocs    = 1'b1;
      iorw    = 1'b0;
      ioaddr  = addr;
      tb_dout = data;
      tb_oe   = 1'b1;
      @(negedge clk);
      iocs   = 1'b0;
      iorw   = 1'b1;
      tb_oe  = 1'b0;
      ioaddr = 2'b00;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
      iocs   = 1'b1;
      iorw   = 1'b1;
      ioaddr = addr;
      tb_oe  = 1'b0;
      #1;
      data = databus;
      @(negedge clk);
      iocs   = 1'b0;
      ioaddr = 2'b00;
   endtask

   // One 8N1 frame at 64 cycles per bit (divisor 4).
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (64) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (64) @(negedge clk);
      rxd = 1'b1;
   endtask

   // Model of the one-byte receive buffer: a new byte replaces an unread one.
   task automatic push_rx_overwrite(input logic [7:0] b);
      if (rx_q.size() != 0)
         void'(rx_q.pop_back());
      rx_q.push_back(b);
   endtask

   task automatic wait_rda();
      for (int k = 0; k < 100 && !rda; k++)
         @(negedge clk);
      chk("rda_set", 16'(rda), 16'd1);
   endtask

   task automatic check_read(input string tag);
      logic [7:0] d;
      logic [7:0] e;
      bus_read(2'b00, d);
      e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      chk(tag, 16'(d), 16'(e));
   endtask

   // Main sequence
   initial begin
      logic [7:0] d;
      logic [9:0] frame;
      int         low_cnt;
      bit         seen_hi;
      bit         found;

      rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
      tb_oe = 1'b0; tb_dout = 8'h00; rxd = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_txd", 16'(txd), 16'd1);
      chk("rst_tbr", 16'(tbr), 16'd1);
      chk("rst_rda", 16'(rda), 16'd0);
      rst = 1'b0;
      @(negedge clk);
      bus_read(2'b01, d);
      chk("status_after_rst", 16'(d), 16'h0002);

      // Reading address 10 must leave the bus free for another driver.
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10; tb_dout = 8'h00; tb_oe = 1'b1;
      #1;
      chk("bus_released", 16'(databus), 16'h0000);
      @(negedge clk);
      iocs = 1'b0; tb_oe = 1'b0; ioaddr = 2'b00;

      // Reset in the middle of a frame at the default divisor.
      bus_write(2'b00, 8'h5A);
      repeat (50) @(negedge clk);
      chk("pre_rst_tbr", 16'(tbr), 16'd0);
      chk("pre_rst_txd", 16'(txd), 16'd0);
      rst = 1'b1;
      #1;
      chk("async_rst_txd", 16'(txd), 16'd1);
      chk("async_rst_tbr", 16'(tbr), 16'd1);
      chk("async_rst_rda", 16'(rda), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus_read(2'b01, d);
      chk("status_mid_rst", 16'(d), 16'h0002);

      // Divisor 4, then transmit 8'hA5 aligned to the tick phase.
      bus_write(2'b10, 8'h04);
      bus_write(2'b11, 8'h00);
      repeat (3) @(negedge clk);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++)
         tx_q.push_back(frame[i]);
      bus_write(2'b00, 8'hA5);
      low_cnt = 0;
      seen_hi = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (i == 100) begin
            iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tb_dout = 8'hFF; tb_oe = 1'b1;
         end else begin
            iocs = 1'b0; iorw = 1'b1; tb_oe = 1'b0;
         end
         if (i == 0)
            chk("tx_start_latency", 16'(txd), 16'd0);
         if (i < 640 && (i % 64) == 32)
            chk($sformatf("tx_bit%0d", i / 64), 16'(txd), 16'(tx_q.pop_front()));
         if (!seen_hi) begin
            if (tbr) seen_hi = 1'b1;
            else     low_cnt++;
         end
         @(negedge clk);
      end
      iocs = 1'b0; tb_oe = 1'b0;
      chk("tbr_low_cycles", 16'(low_cnt), 16'd640);
      chk("tbr_after_frame", 16'(tbr), 16'd1);
      repeat (100) @(negedge clk);
      chk("tx_ignored_write", 16'(txd), 16'd1);

      // Receive 8'h3C.
      push_rx_overwrite(8'h3C);
      send_rx(8'h3C, 1'b1);
      wait_rda();
      check_read("rx_3c");
      chk("rda_cleared", 16'(rda), 16'd0);

      // Short low glitch must not start a byte.
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rxd = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_rda", 16'(rda), 16'd0);

      // Framing error: byte discarded, buffer still holds 8'h3C.
      rx_q.push_back(8'h3C);
      send_rx(8'h77, 1'b0);
      repeat (200) @(negedge clk);
      chk("framing_rda", 16'(rda), 16'd0);
      check_read("framing_buf");

      // Overrun: second byte replaces the first.
      push_rx_overwrite(8'h11);
      send_rx(8'h11, 1'b1);
      push_rx_overwrite(8'h22);
      send_rx(8'h22, 1'b1);
      wait_rda();
      check_read("overrun");
      chk("overrun_rda_cleared", 16'(rda), 16'd0);

      // Read of 00 in the same cycle a byte completes.
      push_rx_overwrite(8'h44);
      send_rx(8'h44, 1'b1);
      wait_rda();
      rx_q.push_back(8'h66);
      found = 1'b0;
      fork
         send_rx(8'h66, 1'b1);
         begin
            logic [7:0] rd;
            repeat (64 * 9) @(negedge clk);
            for (int k = 0; k < 200 && !found; k++) begin
               iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
               #1;
               rd = databus;
               @(negedge clk);
               if (rda) begin
                  found = 1'b1;
                  chk("simul_old_byte", 16'(rd), 16'(rx_q.pop_front()));
               end
            end
            iocs = 1'b0;
         end
      join
      chk("simul_rda_held", 16'(found), 16'd1);
      if (!found && rx_q.size() > 1)
         void'(rx_q.pop_front());
      check_read("simul_new_byte");
      chk("simul_rda_cleared", 16'(rda), 16'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
